// File: rtl/act_pingpong_buffer.sv
// Double-buffered activation buffer: packs stream beats into words, fills two banks alternately and hands full banks to the PE.
// Optional TLAST framing check is enabled by defining ACTBUF_TLAST_CHECK_EN.
module act_pingpong_buffer #(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned PACK   = 2,
    parameter int unsigned AWIDTH = 13,
    parameter int unsigned DEPTH  = 8192
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [IN_W-1:0]        ActDMA_V_TDATA,
    input  logic                   ActDMA_V_TVALID,
    output logic                   ActDMA_V_TREADY,
`ifdef ACTBUF_TLAST_CHECK_EN
    input  logic                   ActDMA_V_TLAST,
`endif
    output logic                   SyncSig_V,
    output logic                   SyncSig_V_ap_vld,
    input  logic                   SyncSig_V_ap_ack,
    input  logic                   RdDone,
    input  logic [AWIDTH-1:0]      ActBuf_Data_address0,
    input  logic                   ActBuf_Data_ce0,
    output logic [IN_W*PACK-1:0]   ActBuf_Data_q0,
    output logic                   FrameErr
);

    localparam int unsigned WW   = IN_W * PACK;
    localparam int unsigned LW   = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int unsigned IDXW = $clog2(DEPTH);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FULL  = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    logic [1:0]        state_q [2];
    logic [1:0]        state_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [AWIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [WW-1:0]     pack_q, pack_d;
    logic              tready_q, tready_d;
    logic              vld_q, vld_d;
    logic [WW-1:0]     rdata_q;

    logic              beat_acc_c;
    logic              last_lane_c;
    logic              last_addr_c;
    logic              take_c;
    logic              any_busy_c;
    logic              mem_we_c;
    logic [WW-1:0]     word_c;

    logic [WW-1:0]     mem_q [2][DEPTH];

    assign beat_acc_c  = ActDMA_V_TVALID && tready_q;
    assign last_lane_c = (lane_q == LW'(PACK - 1));
    assign last_addr_c = (wr_addr_q == AWIDTH'(DEPTH - 1));
    assign take_c      = vld_q && SyncSig_V_ap_ack;
    assign any_busy_c  = (state_q[0] == ST_BUSY) || (state_q[1] == ST_BUSY);

    // State register: bank states, pointers, packing register and registered handshake outputs
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= '{ST_EMPTY, ST_EMPTY};
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_addr_q <= '0;
            lane_q    <= '0;
            pack_q    <= '0;
            tready_q  <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_addr_q <= wr_addr_d;
            lane_q    <= lane_d;
            pack_q    <= pack_d;
            tready_q  <= tready_d;
            vld_q     <= vld_d;
        end
    end

    // Next state: writer packing/frame completion, PE take and release
    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_addr_d = wr_addr_q;
        lane_d    = lane_q;
        pack_d    = pack_q;
        mem_we_c  = 1'b0;
        word_c    = pack_q;
        for (int unsigned l = 0; l < PACK; l++) begin
            if (lane_q == LW'(l)) begin
                word_c[l*IN_W +: IN_W] = ActDMA_V_TDATA;
            end
        end

        if (beat_acc_c) begin
            if (last_lane_c) begin
                mem_we_c = 1'b1;
                lane_d   = '0;
                if (last_addr_c) begin
                    state_d[wr_bank_q] = ST_FULL;
                    wr_bank_d          = ~wr_bank_q;
                    wr_addr_d          = '0;
                end else begin
                    wr_addr_d = wr_addr_q + AWIDTH'(1);
                end
            end else begin
                lane_d = lane_q + LW'(1);
                pack_d = word_c;
            end
        end

        // Only the read bank can ever be BUSY since banks are consumed in fill order
        if (take_c) begin
            state_d[rd_bank_q] = ST_BUSY;
        end
        if (RdDone && any_busy_c) begin
            state_d[rd_bank_q] = ST_EMPTY;
            rd_bank_d          = ~rd_bank_q;
        end
    end

    // Output decode from the next state so the handshake outputs can be registered
    always_comb begin
        tready_d = (state_d[wr_bank_d] == ST_EMPTY);
        vld_d    = (state_d[rd_bank_d] == ST_FULL) &&
                   (state_d[0] != ST_BUSY) && (state_d[1] != ST_BUSY);
    end

    always_ff @(posedge ap_clk) begin
        if (mem_we_c) begin
            mem_q[wr_bank_q][wr_addr_q[IDXW-1:0]] <= word_c;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            rdata_q <= '0;
        end else if (ActBuf_Data_ce0) begin
            rdata_q <= mem_q[rd_bank_q][ActBuf_Data_address0[IDXW-1:0]];
        end
    end

`ifdef ACTBUF_TLAST_CHECK_EN
    logic frame_err_q;

    // TLAST must coincide exactly with the beat that completes a frame
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            frame_err_q <= 1'b0;
        end else if (beat_acc_c && (ActDMA_V_TLAST != (last_lane_c && last_addr_c))) begin
            frame_err_q <= 1'b1;
        end
    end

    assign FrameErr = frame_err_q;
`else
    assign FrameErr = 1'b0;
`endif

    assign ActDMA_V_TREADY  = tready_q;
    assign SyncSig_V        = rd_bank_q;
    assign SyncSig_V_ap_vld = vld_q;
    assign ActBuf_Data_q0   = rdata_q;

endmodule

// File: tb/tb_act_pingpong_buffer.sv
// Bench for act_pingpong_buffer: directed scenarios plus random traffic checked every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_act_pingpong_buffer;

    localparam int unsigned IN_W   = 8;
    localparam int unsigned PACK   = 2;
    localparam int unsigned AWIDTH = 13;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned WW     = IN_W * PACK;
    localparam int unsigned FB     = DEPTH * PACK;

    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic [IN_W-1:0]   ActDMA_V_TDATA = '0;
    logic              ActDMA_V_TVALID = 1'b0;
    logic              ActDMA_V_TREADY;
    logic              ActDMA_V_TLAST = 1'b0;
    logic              SyncSig_V;
    logic              SyncSig_V_ap_vld;
    logic              SyncSig_V_ap_ack = 1'b0;
    logic              RdDone = 1'b0;
    logic [AWIDTH-1:0] ActBuf_Data_address0 = '0;
    logic              ActBuf_Data_ce0 = 1'b0;
    logic [WW-1:0]     ActBuf_Data_q0;
    logic              FrameErr;

    int n_checks = 0;
    int n_pass   = 0;

    act_pingpong_buffer #(.IN_W(IN_W), .PACK(PACK), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) dut (
        .ap_clk               (ap_clk),
        .ap_rst               (ap_rst),
        .ActDMA_V_TDATA       (ActDMA_V_TDATA),
        .ActDMA_V_TVALID      (ActDMA_V_TVALID),
        .ActDMA_V_TREADY      (ActDMA_V_TREADY),
`ifdef ACTBUF_TLAST_CHECK_EN
        .ActDMA_V_TLAST       (ActDMA_V_TLAST),
`endif
        .SyncSig_V            (SyncSig_V),
        .SyncSig_V_ap_vld     (SyncSig_V_ap_vld),
        .SyncSig_V_ap_ack     (SyncSig_V_ap_ack),
        .RdDone               (RdDone),
        .ActBuf_Data_address0 (ActBuf_Data_address0),
        .ActBuf_Data_ce0      (ActBuf_Data_ce0),
        .ActBuf_Data_q0       (ActBuf_Data_q0),
        .FrameErr             (FrameErr)
    );

    always #5 ap_clk = ~ap_clk;

    // Frame-level model: bank status 0=empty 1=full 2=in use by PE, beat count within the frame
    int unsigned m_st [2] = '{0, 0};
    int unsigned m_wb = 0;
    int unsigned m_rb = 0;
    int unsigned m_beat = 0;
    int unsigned m_mem [2][DEPTH];
    int unsigned m_q = 0;
    bit          m_tready = 1'b0;
    bit          m_vld = 1'b0;
    bit          m_ferr = 1'b0;

    function automatic bit m_busy();
        return (m_st[0] == 2) || (m_st[1] == 2);
    endfunction

    always @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            m_st = '{0, 0};
            m_wb = 0; m_rb = 0; m_beat = 0; m_q = 0;
            m_tready = 1'b0; m_vld = 1'b0; m_ferr = 1'b0;
        end else begin
            bit          acc, take, done;
            int unsigned w, sh;
            acc  = ActDMA_V_TVALID && m_tready;
            take = m_vld && SyncSig_V_ap_ack;
            done = RdDone && m_busy();
            if (ActBuf_Data_ce0 && int'(ActBuf_Data_address0) < DEPTH)
                m_q = m_mem[m_rb][int'(ActBuf_Data_address0)];
            if (acc) begin
                w  = m_beat / PACK;
                sh = (m_beat % PACK) * IN_W;
                m_mem[m_wb][w] = (m_mem[m_wb][w] & ~(((1 << IN_W) - 1) << sh)) |
                                 (int'(ActDMA_V_TDATA) << sh);
`ifdef ACTBUF_TLAST_CHECK_EN
                if (ActDMA_V_TLAST != (m_beat == FB - 1)) m_ferr = 1'b1;
`endif
                m_beat++;
                if (m_beat == FB) begin
                    m_st[m_wb] = 1;
                    m_wb = 1 - m_wb;
                    m_beat = 0;
                end
            end
            if (take) m_st[m_rb] = 2;
            if (done) begin
                m_st[m_rb] = 0;
                m_rb = 1 - m_rb;
            end
            m_tready = (m_st[m_wb] == 0);
            m_vld    = (m_st[m_rb] == 1) && !m_busy();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge ap_clk) begin
        chk("tready", 32'(ActDMA_V_TREADY), 32'(m_tready));
        chk("vld", 32'(SyncSig_V_ap_vld), 32'(m_vld));
        chk("sync", 32'(SyncSig_V), 32'(m_rb));
        chk("q0", 32'(ActBuf_Data_q0), 32'(m_q[WW-1:0]));
        chk("frame_err", 32'(FrameErr), 32'(m_ferr));
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d, input bit bad_last);
        int guard = 0;
        ActDMA_V_TVALID = 1'b1;
        ActDMA_V_TDATA  = d;
        ActDMA_V_TLAST  = bad_last ^ (m_beat == FB - 1);
        while (!ActDMA_V_TREADY && guard < 50) begin
            step();
            guard++;
        end
        if (guard == 50) begin
            n_checks++;
            $display("FAIL send_timeout: TREADY stayed 0, want 1 within 50 cycles at %0t", $time);
        end else begin
            step();
        end
        ActDMA_V_TVALID = 1'b0;
        ActDMA_V_TLAST  = 1'b0;
    endtask

    task automatic send_frame(input logic [IN_W-1:0] base);
        for (int i = 0; i < int'(FB); i++) send_beat(IN_W'(int'(base) + i), 1'b0);
    endtask

    task automatic pulse_ack();
        SyncSig_V_ap_ack = 1'b1; step(); SyncSig_V_ap_ack = 1'b0;
    endtask

    task automatic pulse_done();
        RdDone = 1'b1; step(); RdDone = 1'b0;
    endtask

    task automatic read_chk(input int a, input logic [WW-1:0] exp, input string name);
        ActBuf_Data_address0 = AWIDTH'(a);
        ActBuf_Data_ce0 = 1'b1;
        step();
        ActBuf_Data_ce0 = 1'b0;
        chk(name, 32'(ActBuf_Data_q0), 32'(exp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded, want finish");
        $fatal(1);
    end

    initial begin
        logic [WW-1:0] lit1 [4];
        lit1 = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};

        repeat (3) step();
        chk("rst_tready", 32'(ActDMA_V_TREADY), 32'd0);
        chk("rst_q0", 32'(ActBuf_Data_q0), 32'd0);
        ap_rst = 1'b0;
        step();
        chk("tready_after_rst", 32'(ActDMA_V_TREADY), 32'd1);

        // Frame into bank 0, then offered with SyncSig_V=0
        send_frame(8'h01);
        chk("f0_vld", 32'(SyncSig_V_ap_vld), 32'd1);
        chk("f0_sync", 32'(SyncSig_V), 32'd0);
        pulse_ack();
        for (int a = 0; a < 4; a++) read_chk(a, lit1[a], "f0_read");

        // Bank 1 fills while bank 0 is in use; offered only after release
        send_frame(8'h11);
        chk("f1_vld_held", 32'(SyncSig_V_ap_vld), 32'd0);
        pulse_done();
        chk("f1_vld", 32'(SyncSig_V_ap_vld), 32'd1);
        chk("f1_sync", 32'(SyncSig_V), 32'd1);

        // Both banks occupied stalls the writer until release
        pulse_ack();
        send_frame(8'h21);
        chk("both_full_tready", 32'(ActDMA_V_TREADY), 32'd0);
        read_chk(0, 16'h1211, "f1_read0");
        pulse_done();
        chk("release_tready", 32'(ActDMA_V_TREADY), 32'd1);
        chk("release_vld", 32'(SyncSig_V_ap_vld), 32'd1);
        chk("release_sync", 32'(SyncSig_V), 32'd0);

        // Release coinciding with frame completion
        pulse_ack();
        for (int i = 0; i < int'(FB) - 1; i++) send_beat(IN_W'(8'h31 + i), 1'b0);
        RdDone = 1'b1;
        send_beat(8'h38, 1'b0);
        RdDone = 1'b0;
        chk("same_edge_tready", 32'(ActDMA_V_TREADY), 32'd1);
        chk("same_edge_vld", 32'(SyncSig_V_ap_vld), 32'd1);
        chk("same_edge_sync", 32'(SyncSig_V), 32'd1);
        pulse_ack();
        read_chk(3, 16'h3837, "f3_read3");
        pulse_done();

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 3; i++) send_beat(IN_W'(8'h41 + i), 1'b0);
        ap_rst = 1'b1;
        step();
        chk("midrst_q0", 32'(ActBuf_Data_q0), 32'd0);
        chk("midrst_tready", 32'(ActDMA_V_TREADY), 32'd0);
        ap_rst = 1'b0;
        step();
        send_frame(8'h10);
        chk("postrst_vld", 32'(SyncSig_V_ap_vld), 32'd1);
        chk("postrst_sync", 32'(SyncSig_V), 32'd0);
        pulse_ack();
        read_chk(0, 16'h1110, "postrst_read0");
        read_chk(3, 16'h1716, "postrst_read3");
        pulse_done();

`ifdef ACTBUF_TLAST_CHECK_EN
        // Early TLAST on beat 5 raises a sticky framing error
        for (int i = 0; i < 4; i++) send_beat(IN_W'(8'h50 + i), 1'b0);
        send_beat(8'h54, 1'b1);
        chk("ferr_set", 32'(FrameErr), 32'd1);
        for (int i = 5; i < int'(FB); i++) send_beat(IN_W'(8'h50 + i), 1'b0);
        pulse_ack();
        pulse_done();
        send_frame(8'h60);
        chk("ferr_sticky", 32'(FrameErr), 32'd1);
`endif

        // Random traffic, including acks without offer and releases with nothing in use
        for (int c = 0; c < 3000; c++) begin
            ActDMA_V_TVALID      = ($urandom_range(0, 3) != 0);
            ActDMA_V_TDATA       = IN_W'($urandom);
            ActDMA_V_TLAST       = (m_beat == FB - 1);
            SyncSig_V_ap_ack     = ($urandom_range(0, 3) == 0);
            RdDone               = ($urandom_range(0, 11) == 0);
            ActBuf_Data_ce0      = m_busy() && ($urandom_range(0, 1) == 1);
            ActBuf_Data_address0 = AWIDTH'($urandom_range(0, DEPTH - 1));
            step();
        end
        ActDMA_V_TVALID = 1'b0;
        SyncSig_V_ap_ack = 1'b0;
        RdDone = 1'b0;
        ActBuf_Data_ce0 = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
